// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data memory between the CPU load/store port (A)
// and an auxiliary master (B). At most one access is granted per cycle;
// load data returns registered one cycle after the grant. A contention
// pointer and a saturating contention counter are kept for monitoring.
//
// Optional feature macro: DM_ARB_RR_EN
//   defined   -> round-robin on contention (the port that is not `last` wins)
//   undefined -> fixed priority, port A always wins contention
module dm_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   // port A (CPU)
   input  logic             a_req,
   input  logic             a_we,
   input  logic [2:0]       a_size,
   input  logic [31:0]      a_addr,
   input  logic [31:0]      a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [31:0]      a_rdata,
   // port B (auxiliary master)
   input  logic             b_req,
   input  logic             b_we,
   input  logic [2:0]       b_size,
   input  logic [31:0]      b_addr,
   input  logic [31:0]      b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [31:0]      b_rdata,
   // data memory pins
   output logic             dm_we,
   output logic [2:0]       dm_size,
   output logic [31:0]      dm_wd,
   output logic [31:0]      dm_a,
   input  logic [31:0]      dm_rd,
   // monitoring
   output logic [CNT_W-1:0] conflict_cnt
);

   // last port granted under contention: 0 = A, 1 = B
   logic             last_q, last_d;
   logic             a_rvalid_q, a_rvalid_d;
   logic             b_rvalid_q, b_rvalid_d;
   logic [31:0]      a_rdata_q, a_rdata_d;
   logic [31:0]      b_rdata_q, b_rdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic both_req;
   logic win_a;
   logic win_b;

   assign both_req = a_req & b_req;

`ifdef DM_ARB_RR_EN
   // Round-robin: under contention the port that did not win last time wins.
   assign win_a = a_req & (~b_req | last_q);
   assign win_b = b_req & (~a_req | ~last_q);
`else
   // Fixed priority: A always wins contention; `last` is tracked but unused here.
   assign win_a = a_req;
   assign win_b = b_req & ~a_req;
`endif

   // Grants are suppressed while reset is high so no store can reach DM.
   assign a_gnt = win_a & ~reset;
   assign b_gnt = win_b & ~reset;

   // Steer the winning port's command onto the DM pins; idle pins are zero.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      dm_we   = 1'b0;
      dm_size = 3'd0;
      dm_wd   = 32'd0;
      dm_a    = 32'd0;
      if (a_gnt) begin
         dm_we   = a_we;
         dm_size = a_size;
         dm_wd   = a_wdata;
         dm_a    = a_addr;
      end else if (b_gnt) begin
         dm_we   = b_we;
         dm_size = b_size;
         dm_wd   = b_wdata;
         dm_a    = b_addr;
      end
   end

   // Next-state: contention pointer, load capture and contention counter.
   always_comb begin
      last_d     = last_q;
      a_rvalid_d = a_gnt & ~a_we;
      b_rvalid_d = b_gnt & ~b_we;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      cnt_d      = cnt_q;

      if (both_req && (a_gnt || b_gnt)) begin
         last_d = b_gnt;
      end
      if (a_gnt && !a_we) begin
         a_rdata_d = dm_rd;
      end
      if (b_gnt && !b_we) begin
         b_rdata_d = dm_rd;
      end
      // Saturate at all-ones rather than wrapping.
      if (both_req && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset; reset drops any in-flight rvalid.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (reset) begin
         last_q     <= 1'b1;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= 32'd0;
         b_rdata_q  <= 32'd0;
         cnt_q      <= '0;
      end else begin
         last_q     <= last_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         cnt_q      <= cnt_d;
      end
   end

   assign a_rvalid     = a_rvalid_q;
   assign b_rvalid     = b_rvalid_q;
   assign a_rdata      = a_rdata_q;
   assign b_rdata      = b_rdata_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural data
// memory, a reference memory and per-port queues of expected load data.
// Expected grants are written into each step; the contention cases follow
// DM_ARB_RR_EN when the bench is built with the macro.
module tb_dm_arbiter;

   localparam int unsigned CNT_W = 4;
   localparam logic [2:0]  SZ_W  = 3'b010;

   logic             clk = 1'b0;
   logic             reset;
   logic             a_req, a_we, b_req, b_we;
   logic [2:0]       a_size, b_size;
   logic [31:0]      a_addr, a_wdata, b_addr, b_wdata;
   logic             a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [31:0]      a_rdata, b_rdata;
   logic             dm_we;
   logic [2:0]       dm_size;
   logic [31:0]      dm_wd, dm_a, dm_rd;
   logic [CNT_W-1:0] conflict_cnt;

   dm_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .dm_we(dm_we), .dm_size(dm_size), .dm_wd(dm_wd), .dm_a(dm_a), .dm_rd(dm_rd),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural DM: combinational read, write on the rising edge.
   logic [31:0] mem [0:255];
   assign dm_rd = mem[dm_a[9:2]];
   always @(posedge clk) begin
      if (dm_we) mem[dm_a[9:2]] <= dm_wd;
   end

   // Reference model state.
   logic [31:0] ref_mem [0:255];
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic        exp_a_rv, exp_b_rv;
   logic [31:0] last_a, last_b;
   int          exp_cnt;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      a_req = req; a_we = we; a_size = SZ_W; a_addr = addr; a_wdata = wd;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      b_req = req; b_we = we; b_size = SZ_W; b_addr = addr; b_wdata = wd;
   endtask

   // One clock cycle: check mid-cycle, update the model, advance past the edge.
   task automatic cycle(input logic ea, input logic eb, input string tag);
      logic        e_we;
      logic [2:0]  e_sz;
      logic [31:0] e_a, e_wd;
      @(negedge clk);
      // registered outputs from the previous cycle
      chk({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(exp_a_rv));
      chk({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(exp_b_rv));
      if (exp_a_rv) begin
         if (qa.size() > 0) last_a = qa.pop_front();
         else begin n_vec++; n_err++; $error("FAIL %s.qa_empty: observed 0 expected 1", tag); end
      end
      if (exp_b_rv) begin
         if (qb.size() > 0) last_b = qb.pop_front();
         else begin n_vec++; n_err++; $error("FAIL %s.qb_empty: observed 0 expected 1", tag); end
      end
      chk({tag, ".a_rdata"}, a_rdata, last_a);
      chk({tag, ".b_rdata"}, b_rdata, last_b);
      chk({tag, ".cnt"}, 32'(conflict_cnt), 32'(exp_cnt));
      // combinational grant and DM drive
      chk({tag, ".a_gnt"}, 32'(a_gnt), 32'(ea));
      chk({tag, ".b_gnt"}, 32'(b_gnt), 32'(eb));
      e_we = 1'b0; e_sz = 3'd0; e_a = 32'd0; e_wd = 32'd0;
      if (ea)      begin e_we = a_we; e_sz = a_size; e_a = a_addr; e_wd = a_wdata; end
      else if (eb) begin e_we = b_we; e_sz = b_size; e_a = b_addr; e_wd = b_wdata; end
      chk({tag, ".dm_we"}, 32'(dm_we), 32'(e_we));
      chk({tag, ".dm_a"}, dm_a, e_a);
      chk({tag, ".dm_wd"}, dm_wd, e_wd);
      chk({tag, ".dm_size"}, 32'(dm_size), 32'(e_sz));
      // model update for the coming edge
      if (reset) begin
         exp_cnt = 0; exp_a_rv = 1'b0; exp_b_rv = 1'b0;
         last_a = 32'd0; last_b = 32'd0;
         qa.delete(); qb.delete();
      end else begin
         if (a_req && b_req && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
         exp_a_rv = ea & ~a_we;
         exp_b_rv = eb & ~b_we;
         if (exp_a_rv) qa.push_back(ref_mem[a_addr[9:2]]);
         if (exp_b_rv) qb.push_back(ref_mem[b_addr[9:2]]);
         if (e_we) ref_mem[e_a[9:2]] = e_wd;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic rr;
`ifdef DM_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA500_0000 | i;
         ref_mem[i] = 32'hA500_0000 | i;
      end
      exp_a_rv = 1'b0; exp_b_rv = 1'b0;
      last_a = 32'd0; last_b = 32'd0; exp_cnt = 0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);

      // reset for two cycles, with both ports requesting to prove grants stay low
      reset = 1'b1;
      cycle(0, 0, "rst0");
      set_a(1, 1, 32'h40, 32'h1111_1111);
      set_b(1, 1, 32'h44, 32'h2222_2222);
      cycle(0, 0, "rst1");
      reset = 1'b0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      cycle(0, 0, "idle");

      // port A alone: store then load back
      set_a(1, 1, 32'h10, 32'hDEAD_BEEF);
      cycle(1, 0, "a_st");
      set_a(1, 0, 32'h10, 32'h0);
      cycle(1, 0, "a_ld");
      set_a(0, 0, 0, 0);
      cycle(0, 0, "a_rv");

      // back-to-back loads on A, then a lone B load
      set_a(1, 0, 32'h10, 0);
      cycle(1, 0, "a_b2b0");
      set_a(1, 0, 32'h24, 0);
      cycle(1, 0, "a_b2b1");
      set_a(0, 0, 0, 0);
      set_b(1, 0, 32'h30, 0);
      cycle(0, 1, "b_ld");
      set_b(0, 0, 0, 0);
      cycle(0, 0, "b_rv");

      // contention: both ports load for four cycles, then A drops
      set_a(1, 0, 32'h10, 0);
      set_b(1, 0, 32'h34, 0);
      for (int i = 0; i < 4; i++) begin
         if (rr) cycle(i % 2 == 0, i % 2 == 1, "cont");
         else    cycle(1, 0, "cont");
      end
      set_a(0, 0, 0, 0);
      cycle(0, 1, "cont_adrop");
      set_b(0, 0, 0, 0);
      cycle(0, 0, "cont_end");

      // cross-port read-after-write
      set_b(1, 1, 32'h20, 32'h1234_5678);
      cycle(0, 1, "raw_bst");
      set_b(0, 0, 0, 0);
      set_a(1, 0, 32'h20, 0);
      cycle(1, 0, "raw_ald");
      set_a(0, 0, 0, 0);
      cycle(0, 0, "raw_rv");

      // reset the cycle after an A load grant
      set_a(1, 0, 32'h20, 0);
      cycle(1, 0, "mid_ld");
      reset = 1'b1;
      set_a(1, 0, 32'h10, 0);
      set_b(1, 0, 32'h14, 0);
      cycle(0, 0, "mid_rst");
      reset = 1'b0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      cycle(0, 0, "mid_after");

      // saturation: 20 contention cycles on a 4-bit counter
      set_a(1, 0, 32'h10, 0);
      set_b(1, 0, 32'h14, 0);
      for (int i = 0; i < 20; i++) begin
         if (rr) cycle(i % 2 == 0, i % 2 == 1, "sat");
         else    cycle(1, 0, "sat");
      end
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      cycle(0, 0, "sat_end");
      cycle(0, 0, "sat_hold");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
